eth_io_bridge: RTL and testbench
================================

ETH_IO_BRIDGE -- requirements
Module: eth_io_bridge

Interface
REQ-001 The block SHALL have parameter CMD_STATUS, default 8'h30, meaning status-read command code.
REQ-002 The block SHALL have parameter CMD_MAC, default 8'h31, meaning MAC-set command code.
REQ-003 The block SHALL have parameter CMD_TX, default 8'h32, meaning tx-frame-read command code.
REQ-004 The block SHALL have parameter CMD_RX, default 8'h33, meaning rx-frame-write command code.
REQ-005 The block SHALL have parameter STROBE_W, default 2, meaning strobe/begin pulse high time in clk cycles (>=1).
REQ-006 The block SHALL have port clk, input, 1, the single clock.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port io_enable, input, 1, high for the duration of one io-controller command transfer.
REQ-009 The block SHALL have port io_cmd_start, input, 1, one-cycle pulse with io_cmd valid.
REQ-010 The block SHALL have port io_cmd, input, 8, command code.
REQ-011 The block SHALL have ports io_strobe (input, 1, one-cycle pulse per payload byte) and io_din (input, 8, payload byte).
REQ-012 The block SHALL have port io_dout, output, 8, byte returned to the io controller.
REQ-013 The block SHALL have port status, input, 32, NE2000 status word.
REQ-014 The block SHALL have outputs tx_begin (1), tx_strobe (1) and input tx_byte (8) toward the NE2000 tx buffer.
REQ-015 The block SHALL have outputs rx_begin (1), rx_strobe (1) and rx_byte (8) toward the NE2000 rx buffer.
REQ-016 The block SHALL have outputs mac_begin (1), mac_strobe (1) and mac_byte (8).
REQ-017 The block SHALL have output overrun, 1, sticky flag for a dropped rx/mac byte.

Function
REQ-018 States SHALL be IDLE, STATUS, MAC, TX, RX; io_cmd_start in IDLE SHALL select the state matching io_cmd; an unknown code SHALL stay in IDLE.
REQ-019 Any state SHALL return to IDLE in the cycle after io_enable is sampled low; io_cmd_start outside IDLE SHALL be ignored.
REQ-020 STATUS: status SHALL be snapshotted at io_cmd_start; io_dout SHALL show snapshot byte 3 (bits 31:24) first and advance one byte per io_strobe; after four bytes io_dout SHALL be 8'h00.
REQ-021 MAC: mac_begin SHALL be high STROBE_W cycles starting the cycle after io_cmd_start; bytes received during that window SHALL be queued, not lost.
REQ-022 RX: rx_begin SHALL rise the cycle after io_cmd_start and stay high until IDLE is re-entered, falling only after any pending rx_strobe pulse has completed.
REQ-023 RX/MAC byte path: an accepted byte SHALL be driven on rx_byte/mac_byte one cycle before its strobe rises; the strobe SHALL then stay high STROBE_W cycles and low at least one cycle; byte output SHALL stay stable until the strobe falls.
REQ-024 The block SHALL hold one pending byte while a strobe pulse is busy; a byte arriving with the holding register full SHALL be dropped and set overrun.
REQ-025 RX SHALL strobe at most 1536 bytes per command (11-bit saturating count); later bytes SHALL be dropped silently without setting overrun.
REQ-026 MAC SHALL strobe at most 6 bytes per command; later bytes SHALL be dropped silently.
REQ-027 TX: tx_begin SHALL rise the cycle after io_cmd_start, followed by one prefetch tx_strobe pulse; io_dout SHALL equal tx_byte in TX; each io_strobe SHALL trigger one further tx_strobe pulse; tx_begin SHALL fall on return to IDLE.
REQ-028 io_dout SHALL be 8'h00 in IDLE, MAC and RX.
REQ-029 overrun SHALL clear only on reset or on io_cmd_start of CMD_MAC/CMD_RX.

Reset
REQ-030 While reset is low, the block SHALL force state IDLE; all begin/strobe outputs, rx_byte, mac_byte, io_dout, overrun, counters and the holding register to 0.
REQ-031 Reset asserted mid-transfer SHALL abort immediately, driving low any begin or strobe then high, including mid-pulse.

Verification
REQ-032 CMD_STATUS, status=32'h12A50034, four io_strobes -> io_dout 8'h12, 8'hA5, 8'h00, 8'h34, then 8'h00.
REQ-033 CMD_MAC with 7 bytes 00,11,22,33,44,55,66 spaced 4 clks -> one mac_begin pulse, exactly 6 mac_strobe pulses, mac_byte 00..55 stable at each falling edge, overrun=0.
REQ-034 CMD_RX with 3 back-to-back io_strobes (AA,BB,CC) -> one byte held, CC dropped, overrun=1, rx_strobe pulses carry AA,BB, rx_begin falls after the last pulse once io_enable drops.
REQ-035 CMD_RX with 1540 bytes at 4-clk spacing -> exactly 1536 rx_strobe pulses, overrun=0.
REQ-036 CMD_TX with a tx model returning 8'h10+n on the nth strobe, 3 io_strobes -> io_dout 10,11,12, 4 tx_strobe pulses total, tx_begin falls one cycle after io_enable is sampled low.
REQ-037 Reset pulled low during an rx_strobe high phase -> rx_strobe and rx_begin low asynchronously, state IDLE, next CMD_RX works normally.

Source files
------------

// File: rtl/eth_io_bridge.sv
// eth_io_bridge: bridges a byte-serial io-controller command channel to the
// NE2000 status word, tx buffer (read), rx buffer (write) and MAC register.
// A shared byte engine paces rx/mac bytes into fixed-width strobe pulses with a
// single-entry holding register; a separate pulse generator fetches tx bytes.
module eth_io_bridge #(
  parameter logic [7:0] CMD_STATUS = 8'h30,
  parameter logic [7:0] CMD_MAC    = 8'h31,
  parameter logic [7:0] CMD_TX     = 8'h32,
  parameter logic [7:0] CMD_RX     = 8'h33,
  parameter int         STROBE_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_enable,
  input  logic        io_cmd_start,
  input  logic [7:0]  io_cmd,
  input  logic        io_strobe,
  input  logic [7:0]  io_din,
  output logic [7:0]  io_dout,
  input  logic [31:0] status,
  output logic        tx_begin,
  output logic        tx_strobe,
  input  logic [7:0]  tx_byte,
  output logic        rx_begin,
  output logic        rx_strobe,
  output logic [7:0]  rx_byte,
  output logic        mac_begin,
  output logic        mac_strobe,
  output logic [7:0]  mac_byte,
  output logic        overrun
);

  // One counter width covers both 0..STROBE_W-1 (pulse high time) and
  // 0..STROBE_W (mac_begin window).
  localparam int            CW        = $clog2(STROBE_W + 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(STROBE_W - 1);
  localparam logic [CW-1:0] BEGIN_LEN = CW'(STROBE_W);
  localparam logic [10:0]   RX_LIMIT  = 11'd1536;
  localparam logic [10:0]   MAC_LIMIT = 11'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STATUS,
    ST_MAC,
    ST_TX,
    ST_RX
  } state_t;

  // PH_SETUP drives the byte one cycle ahead of the strobe; PH_LOW guarantees
  // the strobe is low for at least one cycle while the byte is still held.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_HIGH,
    PH_LOW
  } phase_t;

  state_t        state_reg, state_next;

  logic [31:0]   stat_reg;
  logic [2:0]    stat_idx_reg;
  logic [7:0]    stat_byte [4];

  logic [CW-1:0] mac_begin_cnt_reg;

  phase_t        bphase_reg;
  logic [CW-1:0] bhigh_cnt_reg;
  logic [7:0]    byte_reg;
  logic          hold_valid_reg;
  logic [7:0]    hold_data_reg;
  logic          tgt_mac_reg;
  logic [10:0]   byte_cnt_reg;
  logic          overrun_reg;

  phase_t        tx_phase_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [3:0]    tx_pend_reg;

  logic          cmd_accept;
  logic          io_beat;
  logic          in_byte_state;
  logic [10:0]   byte_limit;
  logic          byte_req;
  logic          eng_ready;
  logic          hold_consume;
  logic          take_direct;
  logic          take_hold;
  logic          byte_drop;
  logic          tx_launch;

  // Status word bytes, most significant byte first.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stat
      assign stat_byte[gi] = stat_reg[8*(3-gi) +: 8];
    end
  endgenerate

  // Shared qualifiers for command acceptance and payload byte handling.
  always_comb begin
    cmd_accept    = (state_reg == ST_IDLE) && io_cmd_start;
    io_beat       = io_strobe && io_enable;
    in_byte_state = (state_reg == ST_RX) || (state_reg == ST_MAC);
    byte_limit    = (state_reg == ST_MAC) ? MAC_LIMIT : RX_LIMIT;
    byte_req      = io_beat && in_byte_state && (byte_cnt_reg < byte_limit);
    eng_ready     = (bphase_reg == PH_IDLE) || ((bphase_reg == PH_LOW) && !hold_valid_reg);
    hold_consume  = (bphase_reg == PH_LOW) && hold_valid_reg;
    take_direct   = byte_req && eng_ready;
    take_hold     = byte_req && !eng_ready && (!hold_valid_reg || hold_consume);
    byte_drop     = byte_req && !eng_ready && hold_valid_reg && !hold_consume;
    tx_launch     = (tx_phase_reg == PH_IDLE) && (tx_pend_reg != 4'd0) && (state_reg == ST_TX);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state: RX lingers until the byte engine has finished its pulse.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (io_cmd_start) begin
          if (io_cmd == CMD_STATUS)   state_next = ST_STATUS;
          else if (io_cmd == CMD_MAC) state_next = ST_MAC;
          else if (io_cmd == CMD_TX)  state_next = ST_TX;
          else if (io_cmd == CMD_RX)  state_next = ST_RX;
          else                        state_next = ST_IDLE;
        end
      end
      ST_RX: begin
        if (!io_enable && eng_ready) state_next = ST_IDLE;
      end
      default: begin
        if (!io_enable) state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    io_dout = 8'h00;
    case (state_reg)
      ST_STATUS: if (stat_idx_reg < 3'd4) io_dout = stat_byte[stat_idx_reg[1:0]];
      ST_TX:     io_dout = tx_byte;
      default:   io_dout = 8'h00;
    endcase
    tx_begin   = (state_reg == ST_TX);
    rx_begin   = (state_reg == ST_RX);
    mac_begin  = (mac_begin_cnt_reg != '0);
    tx_strobe  = (tx_phase_reg == PH_HIGH);
    rx_strobe  = (bphase_reg == PH_HIGH) && !tgt_mac_reg;
    mac_strobe = (bphase_reg == PH_HIGH) && tgt_mac_reg;
    rx_byte    = tgt_mac_reg ? 8'h00 : byte_reg;
    mac_byte   = tgt_mac_reg ? byte_reg : 8'h00;
  end

  assign overrun = overrun_reg;

  // Status snapshot and read index; index saturates past the last byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_reg     <= '0;
      stat_idx_reg <= '0;
    end else if (cmd_accept && (io_cmd == CMD_STATUS)) begin
      stat_reg     <= status;
      stat_idx_reg <= '0;
    end else if ((state_reg == ST_STATUS) && io_beat && (stat_idx_reg != 3'd4)) begin
      stat_idx_reg <= stat_idx_reg + 3'd1;
    end
  end

  // mac_begin window timer, started by an accepted MAC command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_begin_cnt_reg <= '0;
    end else if (cmd_accept && (io_cmd == CMD_MAC)) begin
      mac_begin_cnt_reg <= BEGIN_LEN;
    end else if (mac_begin_cnt_reg != '0) begin
      mac_begin_cnt_reg <= mac_begin_cnt_reg - 1'b1;
    end
  end

  // Per-command bookkeeping: target select, byte limit counter, overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_mac_reg  <= 1'b0;
      byte_cnt_reg <= '0;
      overrun_reg  <= 1'b0;
    end else if (cmd_accept && ((io_cmd == CMD_MAC) || (io_cmd == CMD_RX))) begin
      tgt_mac_reg  <= (io_cmd == CMD_MAC);
      byte_cnt_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      if (take_direct || take_hold) byte_cnt_reg <= byte_cnt_reg + 11'd1;
      if (byte_drop)                overrun_reg  <= 1'b1;
    end
  end

  // Single-entry holding register; refilled in the same cycle it drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (take_hold) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= io_din;
    end else if (hold_consume) begin
      hold_valid_reg <= 1'b0;
    end
  end

  // rx/mac byte engine: setup cycle, STROBE_W high cycles, one low cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bphase_reg    <= PH_IDLE;
      bhigh_cnt_reg <= '0;
      byte_reg      <= '0;
    end else begin
      case (bphase_reg)
        PH_IDLE: begin
          if (take_direct) begin
            byte_reg   <= io_din;
            bphase_reg <= PH_SETUP;
          end
        end
        PH_SETUP: begin
          bphase_reg    <= PH_HIGH;
          bhigh_cnt_reg <= '0;
        end
        PH_HIGH: begin
          if (bhigh_cnt_reg == HIGH_LAST) bphase_reg <= PH_LOW;
          else                            bhigh_cnt_reg <= bhigh_cnt_reg + 1'b1;
        end
        default: begin
          if (hold_valid_reg) begin
            byte_reg   <= hold_data_reg;
            bphase_reg <= PH_SETUP;
          end else if (take_direct) begin
            byte_reg   <= io_din;
            bphase_reg <= PH_SETUP;
          end else begin
            bphase_reg <= PH_IDLE;
          end
        end
      endcase
    end
  end

  // Outstanding tx fetch requests: one prefetch plus one per io_strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_pend_reg <= '0;
    end else if (cmd_accept && (io_cmd == CMD_TX)) begin
      tx_pend_reg <= 4'd1;
    end else if (state_reg != ST_TX) begin
      tx_pend_reg <= '0;
    end else if (io_beat && !tx_launch) begin
      if (tx_pend_reg != 4'hF) tx_pend_reg <= tx_pend_reg + 4'd1;
    end else if (tx_launch && !io_beat) begin
      tx_pend_reg <= tx_pend_reg - 4'd1;
    end
  end

  // tx_strobe pulse generator: STROBE_W high cycles then one low cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_phase_reg <= PH_IDLE;
      tx_cnt_reg   <= '0;
    end else begin
      case (tx_phase_reg)
        PH_IDLE: begin
          if (tx_launch) begin
            tx_phase_reg <= PH_HIGH;
            tx_cnt_reg   <= '0;
          end
        end
        PH_HIGH: begin
          if (tx_cnt_reg == HIGH_LAST) tx_phase_reg <= PH_LOW;
          else                         tx_cnt_reg   <= tx_cnt_reg + 1'b1;
        end
        default: tx_phase_reg <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_io_bridge.sv
// Directed bench for eth_io_bridge: status read, MAC set, rx overrun, rx limit,
// tx prefetch/read and mid-pulse reset abort.
module tb_eth_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_enable;
  logic        io_cmd_start;
  logic [7:0]  io_cmd;
  logic        io_strobe;
  logic [7:0]  io_din;
  logic [7:0]  io_dout;
  logic [31:0] status;
  logic        tx_begin;
  logic        tx_strobe;
  logic [7:0]  tx_byte = 8'h00;
  logic        rx_begin;
  logic        rx_strobe;
  logic [7:0]  rx_byte;
  logic        mac_begin;
  logic        mac_strobe;
  logic [7:0]  mac_byte;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  // Pulse monitors (single writer: the negedge process below).
  int         rx_pulses = 0, mac_pulses = 0, tx_pulses = 0, mb_pulses = 0;
  int         unstable = 0, rx_outside = 0, tx_n = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mac_q[$];
  logic [7:0] rx_cap = 8'h00, mac_cap = 8'h00;
  logic       rx_p = 1'b0, mac_p = 1'b0, tx_p = 1'b0, mb_p = 1'b0;

  int rp, mp, tp, mbp, rq, mq, un, ro;

  always #5 clk = ~clk;

  eth_io_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .io_enable    (io_enable),
    .io_cmd_start (io_cmd_start),
    .io_cmd       (io_cmd),
    .io_strobe    (io_strobe),
    .io_din       (io_din),
    .io_dout      (io_dout),
    .status       (status),
    .tx_begin     (tx_begin),
    .tx_strobe    (tx_strobe),
    .tx_byte      (tx_byte),
    .rx_begin     (rx_begin),
    .rx_strobe    (rx_strobe),
    .rx_byte      (rx_byte),
    .mac_begin    (mac_begin),
    .mac_strobe   (mac_strobe),
    .mac_byte     (mac_byte),
    .overrun      (overrun)
  );

  // Monitors and tx buffer model (returns 8'h10+n on the nth tx_strobe).
  always @(negedge clk) begin
    if (rx_strobe && !rx_p) begin
      rx_pulses++;
      rx_q.push_back(rx_byte);
      rx_cap = rx_byte;
    end else if (reset && (rx_strobe || rx_p) && (rx_byte !== rx_cap)) begin
      unstable++;
    end
    if (mac_strobe && !mac_p) begin
      mac_pulses++;
      mac_q.push_back(mac_byte);
      mac_cap = mac_byte;
    end else if (reset && (mac_strobe || mac_p) && (mac_byte !== mac_cap)) begin
      unstable++;
    end
    if (rx_strobe && !rx_begin) rx_outside++;
    if (tx_strobe && !tx_p) begin
      tx_pulses++;
      tx_byte = 8'h10 + 8'(tx_n);
      tx_n++;
    end
    if (mac_begin && !mb_p) mb_pulses++;
    rx_p  = rx_strobe;
    mac_p = mac_strobe;
    tx_p  = tx_strobe;
    mb_p  = mac_begin;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] code);
    io_enable    = 1'b1;
    io_cmd       = code;
    io_cmd_start = 1'b1;
    tick(1);
    io_cmd_start = 1'b0;
  endtask

  task automatic strobe_byte(input logic [7:0] d);
    io_din    = d;
    io_strobe = 1'b1;
    tick(1);
    io_strobe = 1'b0;
  endtask

  task automatic wait_rx_idle(input int max);
    for (int k = 0; k < max && rx_begin; k++) tick(1);
    chk("rx_begin_fall", 32'(rx_begin), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; io_enable = 1'b0; io_cmd_start = 1'b0; io_cmd = 8'h00;
    io_strobe = 1'b0; io_din = 8'h00; status = 32'h0;
    tick(3);
    chk("rst_dout", 32'(io_dout), 32'h0);
    chk("rst_ctl", 32'({tx_begin, tx_strobe, rx_begin, rx_strobe, mac_begin, mac_strobe, overrun}), 32'h0);
    chk("rst_bytes", 32'({rx_byte, mac_byte}), 32'h0);
    reset = 1'b1;
    tick(2);

    // Unknown command stays idle.
    send_cmd(8'h55);
    chk("unknown_idle", 32'({tx_begin, rx_begin, mac_begin}), 32'h0);
    io_enable = 1'b0;
    tick(2);

    // Status read with snapshot.
    status = 32'h12A50034;
    send_cmd(8'h30);
    status = 32'hFFFFFFFF;
    chk("st_b3", 32'(io_dout), 32'h12);
    strobe_byte(8'h00); chk("st_b2", 32'(io_dout), 32'hA5);
    strobe_byte(8'h00); chk("st_b1", 32'(io_dout), 32'h00);
    strobe_byte(8'h00); chk("st_b0", 32'(io_dout), 32'h34);
    strobe_byte(8'h00); chk("st_end", 32'(io_dout), 32'h00);
    io_enable = 1'b0;
    tick(1);
    chk("st_idle_dout", 32'(io_dout), 32'h00);

    // MAC set: 7 bytes, 4-clk spacing, first byte inside the begin window.
    mp = mac_pulses; mbp = mb_pulses; mq = mac_q.size(); un = unstable;
    send_cmd(8'h31);
    chk("mac_begin_c1", 32'(mac_begin), 32'd1);
    chk("mac_dout", 32'(io_dout), 32'h0);
    strobe_byte(8'h00);
    chk("mac_begin_c2", 32'(mac_begin), 32'd1);
    tick(1);
    chk("mac_begin_end", 32'(mac_begin), 32'd0);
    tick(2);
    for (int i = 1; i < 7; i++) begin
      strobe_byte(8'(8'h11 * i));
      tick(3);
    end
    tick(6);
    io_enable = 1'b0;
    tick(2);
    chk("mac_pulses", 32'(mac_pulses - mp), 32'd6);
    chk("mac_begin_pulses", 32'(mb_pulses - mbp), 32'd1);
    for (int k = 0; k < 6; k++) chk("mac_byte", 32'(mac_q[mq + k]), 32'(8'h11 * k));
    chk("mac_stable", 32'(unstable - un), 32'd0);
    chk("mac_overrun", 32'(overrun), 32'd0);

    // RX overrun: three back-to-back bytes.
    rp = rx_pulses; rq = rx_q.size(); ro = rx_outside; un = unstable;
    send_cmd(8'h33);
    chk("rx_begin_rise", 32'(rx_begin), 32'd1);
    chk("rx_dout", 32'(io_dout), 32'h0);
    io_strobe = 1'b1; io_din = 8'hAA; tick(1);
    io_din = 8'hBB; tick(1);
    io_din = 8'hCC; tick(1);
    io_strobe = 1'b0; io_enable = 1'b0;
    chk("rx_ovr_set", 32'(overrun), 32'd1);
    chk("rx_begin_hold", 32'(rx_begin), 32'd1);
    wait_rx_idle(30);
    chk("rx_ovr_pulses", 32'(rx_pulses - rp), 32'd2);
    chk("rx_ovr_b0", 32'(rx_q[rq]), 32'hAA);
    chk("rx_ovr_b1", 32'(rx_q[rq + 1]), 32'hBB);
    chk("rx_strobe_in_begin", 32'(rx_outside - ro), 32'd0);
    chk("rx_stable", 32'(unstable - un), 32'd0);
    chk("rx_ovr_sticky", 32'(overrun), 32'd1);

    // RX byte limit.
    rp = rx_pulses; rq = rx_q.size();
    send_cmd(8'h33);
    chk("rx_ovr_clear", 32'(overrun), 32'd0);
    for (int i = 0; i < 1540; i++) begin
      strobe_byte(8'(i));
      tick(3);
    end
    tick(6);
    io_enable = 1'b0;
    wait_rx_idle(30);
    chk("rx_lim_pulses", 32'(rx_pulses - rp), 32'd1536);
    chk("rx_lim_first", 32'(rx_q[rq]), 32'h00);
    chk("rx_lim_last", 32'(rx_q[rq + 1535]), 32'hFF);
    chk("rx_lim_overrun", 32'(overrun), 32'd0);

    // TX read with prefetch.
    tp = tx_pulses;
    send_cmd(8'h32);
    chk("tx_begin_rise", 32'(tx_begin), 32'd1);
    chk("tx_strobe_late", 32'(tx_strobe), 32'd0);
    tick(1);
    chk("tx_prefetch", 32'(tx_strobe), 32'd1);
    tick(3);
    chk("tx_dout0", 32'(io_dout), 32'h10);
    for (int k = 1; k <= 3; k++) begin
      strobe_byte(8'h00);
      tick(5);
      chk("tx_dout", 32'(io_dout), 32'(8'h10 + 8'(k)));
    end
    chk("tx_pulses", 32'(tx_pulses - tp), 32'd4);
    io_enable = 1'b0;
    chk("tx_begin_held", 32'(tx_begin), 32'd1);
    tick(1);
    chk("tx_begin_fall", 32'(tx_begin), 32'd0);
    chk("tx_idle_dout", 32'(io_dout), 32'h0);

    // Reset during an rx_strobe high phase.
    send_cmd(8'h33);
    strobe_byte(8'h5A);
    tick(1);
    chk("abort_pre", 32'(rx_strobe), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_strobe", 32'(rx_strobe), 32'd0);
    chk("abort_begin", 32'(rx_begin), 32'd0);
    chk("abort_byte", 32'(rx_byte), 32'h0);
    io_enable = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    rp = rx_pulses; rq = rx_q.size();
    send_cmd(8'h33);
    chk("post_rst_begin", 32'(rx_begin), 32'd1);
    strobe_byte(8'h77);
    tick(6);
    chk("post_rst_pulses", 32'(rx_pulses - rp), 32'd1);
    chk("post_rst_byte", 32'(rx_q[rq]), 32'h77);
    io_enable = 1'b0;
    wait_rx_idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
